// File: rtl/clock_rtc_param_if.sv
// -----------------------------------------------------------------------------
// clock_rtc_param_if
// Purpose : Bundles the control, load, alarm and time/status signals of the
//           clock_rtc_param time-of-day counter.
// Modports:
//   master - drives the i_* controls and reads the o_* results (UI / bench side)
//   slave  - the counter itself: reads i_* and drives o_*
// Signals :
//   i_en, i_load, i_load_hr/min/sec, i_mode12, i_alarm_set,
//   i_alarm_hr_in, i_alarm_min_in, i_alarm_en                  (to counter)
//   o_sec, o_min, o_hr, o_hr_disp, o_pm, o_sec_tick, o_min_wrap,
//   o_hr_wrap, o_day_wrap, o_load_err, o_alarm                  (from counter)
// -----------------------------------------------------------------------------
interface clock_rtc_param_if #(
    parameter int CNT_W = 7
);
    logic             i_en;
    logic             i_load;
    logic [CNT_W-1:0] i_load_hr;
    logic [CNT_W-1:0] i_load_min;
    logic [CNT_W-1:0] i_load_sec;
    logic             i_mode12;
    logic             i_alarm_set;
    logic [CNT_W-1:0] i_alarm_hr_in;
    logic [CNT_W-1:0] i_alarm_min_in;
    logic             i_alarm_en;

    logic [CNT_W-1:0] o_sec;
    logic [CNT_W-1:0] o_min;
    logic [CNT_W-1:0] o_hr;
    logic [CNT_W-1:0] o_hr_disp;
    logic             o_pm;
    logic             o_sec_tick;
    logic             o_min_wrap;
    logic             o_hr_wrap;
    logic             o_day_wrap;
    logic             o_load_err;
    logic             o_alarm;

    modport master (
        output i_en, i_load, i_load_hr, i_load_min, i_load_sec, i_mode12,
               i_alarm_set, i_alarm_hr_in, i_alarm_min_in, i_alarm_en,
        input  o_sec, o_min, o_hr, o_hr_disp, o_pm, o_sec_tick, o_min_wrap,
               o_hr_wrap, o_day_wrap, o_load_err, o_alarm
    );

    modport slave (
        input  i_en, i_load, i_load_hr, i_load_min, i_load_sec, i_mode12,
               i_alarm_set, i_alarm_hr_in, i_alarm_min_in, i_alarm_en,
        output o_sec, o_min, o_hr, o_hr_disp, o_pm, o_sec_tick, o_min_wrap,
               o_hr_wrap, o_day_wrap, o_load_err, o_alarm
    );
endinterface

// File: rtl/clock_rtc_param.sv
// -----------------------------------------------------------------------------
// clock_rtc_param
// Purpose : Parametrised synchronous time-of-day counter (hh:mm:ss) with an
//           integrated prescaler, run enable, range-checked time load,
//           12/24-hour display mapping and a single hh:mm alarm.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - clock_rtc_param_if.slave (controls in, time/status out)
// Notes   : sec/min/hr and all pulse outputs are registers. hr_disp/pm are
//           decoded from the registered hour and the live mode12 input.
// -----------------------------------------------------------------------------
module clock_rtc_param #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int SEC_PER_MIN = 60,
    parameter int MIN_PER_HR  = 60,
    parameter int HR_PER_DAY  = 24,
    parameter int CNT_W       = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    clock_rtc_param_if.slave        bus
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SEC_MAX = CNT_W'(SEC_PER_MIN - 1);
    localparam logic [CNT_W-1:0] MIN_MAX = CNT_W'(MIN_PER_HR - 1);
    localparam logic [CNT_W-1:0] HR_MAX  = CNT_W'(HR_PER_DAY - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_sec;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_hr;
    logic [CNT_W-1:0] r_alarm_hr;
    logic [CNT_W-1:0] r_alarm_min;
    logic             r_sec_tick;
    logic             r_min_wrap;
    logic             r_hr_wrap;
    logic             r_day_wrap;
    logic             r_load_err;
    logic             r_alarm;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic             w_tick;
    logic             w_load_ok;
    logic             w_adv;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic             w_hr_wrap;
    logic [PS_W-1:0]  w_ps_next;
    logic [CNT_W-1:0] w_sec_inc;
    logic [CNT_W-1:0] w_min_inc;
    logic [CNT_W-1:0] w_hr_inc;
    logic [CNT_W-1:0] w_sec_next;
    logic [CNT_W-1:0] w_min_next;
    logic [CNT_W-1:0] w_hr_next;
    logic             w_alarm_hit;

    assign w_tick    = bus.i_en && (r_ps == PS_MAX);
    assign w_load_ok = (bus.i_load_hr  <= HR_MAX)  &&
                       (bus.i_load_min <= MIN_MAX) &&
                       (bus.i_load_sec <= SEC_MAX);

    // Any load cycle (accepted or rejected) suppresses the time advance, so
    // a rejected load that coincides with a tick drops that second.
    assign w_adv = w_tick && !bus.i_load;

    // All three carries are decided from the current registers so the whole
    // rollover happens on a single edge.
    assign w_sec_wrap = (r_sec == SEC_MAX);
    assign w_min_wrap = w_sec_wrap && (r_min == MIN_MAX);
    assign w_hr_wrap  = w_min_wrap && (r_hr == HR_MAX);

    assign w_sec_inc = w_sec_wrap ? '0 : r_sec + ONE;
    assign w_min_inc = w_sec_wrap ? ((r_min == MIN_MAX) ? '0 : r_min + ONE) : r_min;
    assign w_hr_inc  = w_min_wrap ? ((r_hr == HR_MAX) ? '0 : r_hr + ONE) : r_hr;

    always_comb begin
        w_ps_next  = r_ps;
        w_sec_next = r_sec;
        w_min_next = r_min;
        w_hr_next  = r_hr;

        if (bus.i_load && w_load_ok) begin
            // Accepted load restarts the second so the new time gets a full one.
            w_ps_next  = '0;
            w_sec_next = bus.i_load_sec;
            w_min_next = bus.i_load_min;
            w_hr_next  = bus.i_load_hr;
        end else begin
            if (bus.i_en) begin
                w_ps_next = (r_ps == PS_MAX) ? '0 : r_ps + PS_W'(1);
            end
            if (w_adv) begin
                w_sec_next = w_sec_inc;
                w_min_next = w_min_inc;
                w_hr_next  = w_hr_inc;
            end
        end
    end

    // Next second is :00 exactly when sec wraps. Compared against the alarm
    // registers before any same-cycle alarm_set takes effect.
    assign w_alarm_hit = w_adv && bus.i_alarm_en && w_sec_wrap &&
                         (w_min_inc == r_alarm_min) && (w_hr_inc == r_alarm_hr);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps        <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= '0;
            r_alarm_hr  <= '0;
            r_alarm_min <= '0;
            r_sec_tick  <= 1'b0;
            r_min_wrap  <= 1'b0;
            r_hr_wrap   <= 1'b0;
            r_day_wrap  <= 1'b0;
            r_load_err  <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_ps       <= w_ps_next;
            r_sec      <= w_sec_next;
            r_min      <= w_min_next;
            r_hr       <= w_hr_next;

            r_sec_tick <= w_adv;
            r_min_wrap <= w_adv && w_sec_wrap;
            r_hr_wrap  <= w_adv && w_min_wrap;
            r_day_wrap <= w_adv && w_hr_wrap;
            r_load_err <= bus.i_load && !w_load_ok;
            r_alarm    <= w_alarm_hit;

            if (bus.i_alarm_set) begin
                r_alarm_hr  <= bus.i_alarm_hr_in;
                r_alarm_min <= bus.i_alarm_min_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_sec      = r_sec;
    assign bus.o_min      = r_min;
    assign bus.o_hr       = r_hr;
    assign bus.o_sec_tick = r_sec_tick;
    assign bus.o_min_wrap = r_min_wrap;
    assign bus.o_hr_wrap  = r_hr_wrap;
    assign bus.o_day_wrap = r_day_wrap;
    assign bus.o_load_err = r_load_err;
    assign bus.o_alarm    = r_alarm;

    // 12-hour display mapping only exists for a 24-hour day.
    generate
        if (HR_PER_DAY == 24) begin : g_disp12
            localparam logic [CNT_W-1:0] TWELVE = CNT_W'(12);
            logic [CNT_W-1:0] w_hr_disp;
            logic             w_pm;

            always_comb begin
                w_hr_disp = r_hr;
                w_pm      = 1'b0;
                if (bus.i_mode12) begin
                    if (r_hr == '0) begin
                        w_hr_disp = TWELVE;
                    end else if (r_hr < TWELVE) begin
                        w_hr_disp = r_hr;
                    end else if (r_hr == TWELVE) begin
                        w_hr_disp = TWELVE;
                        w_pm      = 1'b1;
                    end else begin
                        w_hr_disp = r_hr - TWELVE;
                        w_pm      = 1'b1;
                    end
                end
            end

            assign bus.o_hr_disp = w_hr_disp;
            assign bus.o_pm      = w_pm;
        end else begin : g_disp24
            assign bus.o_hr_disp = r_hr;
            assign bus.o_pm      = 1'b0;
        end
    endgenerate

endmodule
